code_lock: RTL and testbench

Parametrised keypad combination lock FSM. Sits behind the keypad debouncer and takes one key event per `en` strobe. It checks a `CODE_LEN`-digit sequence against a run-time programmable code and pulses grant or deny. It also counts consecutive failures and locks out entry for a fixed number of `en` ticks, and lets the code be rewritten only immediately after a successful unlock.

---
 rtl/code_lock_pkg.sv | 37 +++
 rtl/code_lock_timer.sv | 34 +++
 rtl/code_lock.sv | 169 ++++++++++++++++
 tb/tb_code_lock.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the keypad combination lock.
package code_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_GRANT,
    S_DENY,
    S_LOCKOUT,
    S_PROG,
    S_PERR
  } state_e;

  localparam int KEYS_MAX = 32;

  function automatic int kw_of(input int num_keys);
    return (num_keys > 1) ? $clog2(num_keys) : 1;
  endfunction

  function automatic int dcw_of(input int code_len);
    return $clog2(code_len + 1);
  endfunction

  localparam int KW  = kw_of(4);
  localparam int DCW = dcw_of(4);

  // A key event is a legal digit only when exactly one key is down.
  function automatic void onehot_idx(input logic [KEYS_MAX-1:0] keys,
                                     output int idx, output logic valid);
    idx   = 0;
    valid = ($countones(keys) == 1);
    for (int i = 0; i < KEYS_MAX; i++) begin
      if (keys[i]) idx = i;
    end
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Loadable down-counter that paces the lockout period.
module code_lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/code_lock.sv
// Keypad combination lock: code entry, failure lockout and post-unlock reprogramming.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int CODE_LEN      = 4,
  parameter logic [CODE_LEN*kw_of(NUM_KEYS)-1:0] DEFAULT_CODE = 8'hE3,
  parameter int MAX_FAILS     = 3,
  parameter int LOCKOUT_TICKS = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [NUM_KEYS-1:0]           keys,
  input  logic                          anykey,
  input  logic                          prog,
  output logic                          unlock,
  output logic                          fail,
  output logic                          locked_out,
  output logic                          prog_active,
  output logic                          prog_err,
  output logic [dcw_of(CODE_LEN)-1:0]   digit_cnt
);

  localparam int KEY_W  = kw_of(NUM_KEYS);
  localparam int CNT_W  = dcw_of(CODE_LEN);
  localparam int CODE_W = CODE_LEN * KEY_W;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int TW     = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;
  localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [TW-1:0]     LOAD_VAL   = TW'(LOCKOUT_TICKS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic                err_q, err_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [CODE_W-1:0]   code_q, code_d, shadow_q, shadow_d;

  int                  key_pos;
  logic                key_onehot, key_valid, digit_bad, last_digit;
  logic [KEY_W-1:0]    key_idx, code_digit;
  logic                tmr_load, tmr_dec, tmr_zero;

  always_comb begin : key_decode
    onehot_idx(KEYS_MAX'(keys), key_pos, key_onehot);
    key_valid  = key_onehot && (key_pos < NUM_KEYS);
    key_idx    = KEY_W'(key_pos);
    code_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_cnt_q == CNT_W'(i)) code_digit = code_q[i*KEY_W +: KEY_W];
    end
    digit_bad  = !key_valid || (key_idx != code_digit);
    last_digit = (digit_cnt_q == LAST_DIGIT);
  end

  always_comb begin : next_state
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    err_d       = err_q;
    fail_cnt_d  = fail_cnt_q;
    code_d      = code_q;
    shadow_d    = shadow_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    if (en) begin
      unique case (state_q)
        // IDLE evaluates digit 0; a stale err is discarded there.
        S_IDLE, S_ENTER: begin
          if (anykey) begin
            if (last_digit) begin
              digit_cnt_d = '0;
              if (((state_q == S_ENTER) && err_q) || digit_bad) begin
                state_d = S_DENY;
                if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
              end else begin
                state_d    = S_GRANT;
                fail_cnt_d = '0;
              end
            end else begin
              state_d     = S_ENTER;
              digit_cnt_d = digit_cnt_q + 1'b1;
              err_d       = ((state_q == S_ENTER) && err_q) || digit_bad;
            end
          end
        end
        S_GRANT: begin
          digit_cnt_d = '0;
          state_d     = prog ? S_PROG : S_IDLE;
        end
        S_DENY: begin
          if (fail_cnt_q == FAIL_MAX) begin
            state_d  = S_LOCKOUT;
            tmr_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOCKOUT: begin
          tmr_dec = 1'b1;
          if (tmr_zero) begin
            state_d    = S_IDLE;
            fail_cnt_d = '0;
          end
        end
        S_PROG: begin
          if (anykey) begin
            if (!key_valid) begin
              state_d     = S_PERR;
              digit_cnt_d = '0;
            end else begin
              for (int i = 0; i < CODE_LEN; i++) begin
                if (digit_cnt_q == CNT_W'(i)) shadow_d[i*KEY_W +: KEY_W] = key_idx;
              end
              if (last_digit) begin
                code_d      = shadow_d;
                state_d     = S_IDLE;
                digit_cnt_d = '0;
              end else begin
                digit_cnt_d = digit_cnt_q + 1'b1;
              end
            end
          end
        end
        S_PERR:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state_q     <= S_IDLE;
      digit_cnt_q <= '0;
      err_q       <= 1'b0;
      fail_cnt_q  <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= DEFAULT_CODE;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      err_q       <= err_d;
      fail_cnt_q  <= fail_cnt_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
    end
  end

  code_lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin : out_decode
    unlock      = (state_q == S_GRANT);
    fail        = (state_q == S_DENY);
    locked_out  = (state_q == S_LOCKOUT);
    prog_active = (state_q == S_PROG);
    prog_err    = (state_q == S_PERR);
    digit_cnt   = digit_cnt_q;
  end

endmodule

// File: tb/tb_code_lock.sv
// Randomised scoreboard bench for code_lock against a queue-based lock model.
module tb_code_lock;

  localparam int CODE_LEN   = 4;
  localparam int MAX_FAILS  = 3;
  localparam int LOCK_TICKS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic       anykey = 1'b0;
  logic       prog = 1'b0;
  logic [3:0] keys = 4'b0;
  logic       unlock, fail, locked_out, prog_active, prog_err;
  logic [2:0] digit_cnt;

  code_lock #(
    .NUM_KEYS      (4),
    .CODE_LEN      (CODE_LEN),
    .DEFAULT_CODE  (8'hE3),
    .MAX_FAILS     (MAX_FAILS),
    .LOCKOUT_TICKS (LOCK_TICKS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .keys        (keys),
    .anykey      (anykey),
    .prog        (prog),
    .unlock      (unlock),
    .fail        (fail),
    .locked_out  (locked_out),
    .prog_active (prog_active),
    .prog_err    (prog_err),
    .digit_cnt   (digit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: digits collected in queues, status as one-tick flags.
  int   m_code[CODE_LEN];
  int   m_entry[$];
  int   m_new[$];
  int   m_fails;
  int   m_lock_left;
  bit   m_grant, m_deny, m_perr, m_prog;
  logic [7:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [7:0] obs();
    return {unlock, fail, locked_out, prog_active, prog_err, digit_cnt};
  endfunction

  function automatic logic [7:0] model_out();
    int dc;
    dc = m_prog ? m_new.size() : m_entry.size();
    return {m_grant, m_deny, (m_lock_left > 0), m_prog, m_perr, 3'(dc)};
  endfunction

  function automatic int digit_of(input logic [3:0] k);
    int d;
    d = -1;
    if ($countones(k) == 1) begin
      for (int i = 0; i < 4; i++) if (k[i]) d = i;
    end
    return d;
  endfunction

  task automatic model_reset();
    m_code = '{3, 0, 2, 3};
    m_entry.delete();
    m_new.delete();
    m_fails = 0;
    m_lock_left = 0;
    m_grant = 0; m_deny = 0; m_perr = 0; m_prog = 0;
  endtask

  task automatic model_step(input bit ak, input logic [3:0] k, input bit pg);
    int d;
    bit ok;
    d = digit_of(k);
    if (m_grant) begin
      m_grant = 0;
      if (pg) begin m_prog = 1; m_new.delete(); end
    end else if (m_deny) begin
      m_deny = 0;
      if (m_fails == MAX_FAILS) m_lock_left = LOCK_TICKS;
    end else if (m_perr) begin
      m_perr = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_prog) begin
      if (ak) begin
        if (d < 0) begin
          m_perr = 1; m_prog = 0; m_new.delete();
        end else begin
          m_new.push_back(d);
          if (m_new.size() == CODE_LEN) begin
            for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_new[i];
            m_prog = 0;
            m_new.delete();
          end
        end
      end
    end else if (ak) begin
      m_entry.push_back(d);
      if (m_entry.size() == CODE_LEN) begin
        ok = 1;
        for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 0;
        if (ok) begin
          m_grant = 1; m_fails = 0;
        end else begin
          m_deny = 1;
          if (m_fails < MAX_FAILS) m_fails++;
        end
        m_entry.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b required %b (unlock,fail,locked_out,prog_active,prog_err,digit_cnt)",
               name, $time, act, exp_v);
    end
  endtask

  task automatic tick(input bit e, input bit ak, input logic [3:0] k, input bit pg);
    @(negedge clk);
    #1;
    en = e; anykey = ak; keys = k; prog = pg;
    if (e) model_step(ak, k, pg);
    exp_q.push_back(model_out());
    $display("tick t=%0t en=%0b anykey=%0b keys=%b prog=%0b exp=%b", $time, e, ak, k, pg, exp_q[$]);
  endtask

  task automatic press(input int d);
    tick(1'b1, 1'b1, 4'(1 << d), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    en = 1'b0; anykey = 1'b0; keys = 4'b0; prog = 1'b0;
    model_reset();
    #1;
    check("reset_async", obs(), 8'h00);
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compares every registered output vector against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [7:0] exp_v;
        exp_v = exp_q.pop_front();
        check("cycle", obs(), exp_v);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    logic [3:0] k;
    model_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_initial", obs(), 8'h00);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;

    // Correct code, then a wrong digit mid-entry, then recovery.
    enter_code(3, 0, 2, 3); idle(2);
    enter_code(3, 1, 2, 3); idle(2);
    enter_code(3, 0, 2, 3); idle(2);

    // Three denials trigger lockout; presses during lockout are ignored.
    repeat (3) begin enter_code(0, 0, 0, 0); idle(1); end
    enter_code(3, 0, 2, 3);
    idle(LOCK_TICKS + 2);
    enter_code(3, 0, 2, 3); idle(1);

    // Multi-key and empty key events count as wrong digits.
    tick(1'b1, 1'b1, 4'b1001, 1'b0); press(0); press(2); press(3); idle(1);
    tick(1'b1, 1'b1, 4'b0000, 1'b0); press(0); press(2); press(3); idle(1);
    enter_code(3, 0, 2, 3); idle(1);

    // Reprogram to 1,1,2,0, then a failed programming pass keeps it.
    enter_code(3, 0, 2, 3);
    tick(1'b1, 1'b0, 4'b0, 1'b1);
    enter_code(1, 1, 2, 0); idle(1);
    enter_code(3, 0, 2, 3); idle(1);
    enter_code(1, 1, 2, 0);
    tick(1'b1, 1'b0, 4'b0, 1'b1);
    press(1);
    tick(1'b1, 1'b1, 4'b0011, 1'b0);
    idle(2);
    enter_code(1, 1, 2, 0); idle(1);

    // Reset mid-entry restores the default code.
    press(1); press(1);
    do_reset();
    enter_code(3, 0, 2, 3); idle(1);

    // Entry with en strobing every third cycle; masked key events are dropped.
    for (int i = 0; i < CODE_LEN; i++) begin
      press(m_code[i]);
      repeat (2) tick(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    repeat (3) begin
      tick(1'b1, 1'b0, 4'b0, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 4'b0, 1'b0);
    end

    // Randomised traffic biased toward the model's current code.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      pos = m_prog ? $urandom_range(0, CODE_LEN - 1) : m_entry.size();
      if (pos >= CODE_LEN) pos = 0;
      if ($urandom_range(0, 9) < 6) k = 4'(1 << m_code[pos]);
      else k = 4'($urandom_range(0, 15));
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), k,
           1'($urandom_range(0, 3) == 0));
    end
    idle(2);

    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
